instr_fetch: RTL

Instruction fetch unit: the requesting end of the instruction-memory interface. Holds the PC, drives a word address to the combinational instruction source, captures the returned word with its PC into a small prefetch FIFO, and presents entries to decode over a valid/ready handshake. Sits between `instr_src` and the decode stage; a redirect input from execute handles branches and jumps.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/instr_fetch_if.sv | 44 ++++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/instr_fetch.sv | 68 ++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-path types and helpers.
// Holds the fetch entry layout and the PC/word-address conversions.
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Byte address to word index as seen by the instruction source.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] byte_addr);
    return {2'b00, byte_addr[XLEN-1:2]};
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] byte_addr);
    return {byte_addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: instruction-memory request side, control from execute,
// and the valid/ready handoff to decode.
interface instr_fetch_if;
  import rv32_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_instr;

  logic            halt;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;

  // Fetch unit side.
  modport master (
    output imem_addr,
    input  imem_instr,
    input  halt,
    input  redirect,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  // Environment side: memory, execute and decode.
  modport slave (
    input  imem_addr,
    output imem_instr,
    output halt,
    output redirect,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries with flush; flush beats push and pop.
// Read data is the head entry, forced to zero when empty.
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap by plain overflow.
      if (push_en) wptr_d = wptr_q + AW'(1);
      if (pop_en)  rptr_d = rptr_q + AW'(1);
      unique case ({push_en, pop_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_en) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  assign rdata = empty ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC register, combinational instruction-source request,
// prefetch FIFO and redirect handling in front of decode.
module instr_fetch
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop;
  fetch_entry_t    push_entry, head;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;
  logic            unused_fifo_full;

  // Push looks only at occupancy at the start of the cycle; a full FIFO
  // never accepts a word even if decode pops the head in the same cycle.
  always_comb begin
    push = !bus.redirect && !bus.halt && (fifo_count < CW'(DEPTH));
    pop  = !fifo_empty && bus.out_ready && !bus.redirect;
    pc_d = pc_q;
    if (bus.redirect) begin
      pc_d = align_pc(bus.redirect_pc);
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= align_pc(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign push_entry = '{pc: pc_q, instr: bus.imem_instr};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign unused_fifo_full = fifo_full;

  assign bus.imem_addr = word_addr(pc_q);
  assign bus.out_valid = !fifo_empty;
  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;

endmodule
